demux16_dispatch: RTL and testbench

- Sequencer that feeds a 16-way 1-bit demux (f input, s[3:0] select, y[15:0] outputs).
- Accepts one data bit per transaction on a valid/ready handshake.
- Chooses a destination channel, either round-robin or directed, among enabled, non-busy channels.
- Drives select and f with a break-before-make pattern: select settles first, f pulses, then f returns low before select may change. This keeps the transistor-level demux tree from glitching onto the wrong output.

---
 rtl/demux16_pkg.sv | 24 ++
 rtl/demux16_dispatch_rr_pick16.sv | 28 ++
 rtl/demux16_dispatch.sv | 160 ++++++++++++++++
 tb/tb_demux16_dispatch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux16_pkg.sv
// Shared types and constants for the 16-way demux dispatcher.
package demux16_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP
    } state_t;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_DIR = 1'b1;

    // Width of the single phase counter that times both SETUP and PULSE.
    function automatic int cnt_width(input int setup_cyc, input int pulse_cyc);
        int max_cyc;
        max_cyc = (setup_cyc > pulse_cyc) ? setup_cyc : pulse_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/demux16_dispatch_rr_pick16.sv
// Combinational 16-way round-robin picker: first set bit of avail after ptr, wrapping 15->0.
module rr_pick16
    import demux16_pkg::*;
(
    input  logic [NCH-1:0]   avail,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from farthest to nearest so the nearest hit after ptr is the one that sticks.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = ptr + SEL_W'(i);
            if (avail[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/demux16_dispatch.sv
// Break-before-make sequencer driving a 16-way 1-bit demux tree (sel settles, f pulses, f drops, then sel may move).
module demux16_dispatch
    import demux16_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_mode,
    input  logic [SEL_W-1:0] in_dest,
    input  logic [NCH-1:0]   chan_en,
    input  logic [NCH-1:0]   chan_busy,
    output logic [SEL_W-1:0] sel,
    output logic             f_out,
    output logic             done,
    output logic [SEL_W-1:0] done_chan,
    output logic             drop_err
);

    localparam int CNT_W = cnt_width(SETUP_CYC, PULSE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             f_q, f_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] done_chan_q, done_chan_d;
    logic             drop_q, drop_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;

    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] tgt;
    logic             legal;
    logic             drop_req;
    logic             accept;

    rr_pick16 u_pick (
        .avail (chan_en & ~chan_busy),
        .ptr   (rr_ptr_q),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Target choice; a directed request to a disabled channel is accepted only to be dropped.
    always_comb begin
        legal    = 1'b0;
        drop_req = 1'b0;
        tgt      = rr_idx;
        if (in_mode == MODE_RR) begin
            legal = rr_found;
        end else begin
            tgt = in_dest;
            if (!chan_en[in_dest]) begin
                legal    = 1'b1;
                drop_req = 1'b1;
            end else begin
                legal = !chan_busy[in_dest];
            end
        end
    end

    assign in_ready = !reset && (state_q == IDLE) && legal;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        f_d         = 1'b0;
        done_d      = 1'b0;
        done_chan_d = done_chan_q;
        drop_d      = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (drop_req) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        sel_d   = tgt;
                        bit_d   = in_bit;
                        cnt_d   = SETUP_LD;
                        if (in_mode == MODE_RR) begin
                            rr_ptr_d = tgt;
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = PULSE;
                    f_d     = bit_q;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            PULSE: begin
                // f drops on the same edge that enters GAP; sel stays put through GAP.
                if (cnt_q == CNT_ONE) begin
                    state_d     = GAP;
                    done_d      = 1'b1;
                    done_chan_d = sel_q;
                end else begin
                    f_d   = bit_q;
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            f_q         <= 1'b0;
            done_q      <= 1'b0;
            done_chan_q <= '0;
            drop_q      <= 1'b0;
            rr_ptr_q    <= SEL_W'(NCH - 1);
            cnt_q       <= '0;
            bit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            f_q         <= f_d;
            done_q      <= done_d;
            done_chan_q <= done_chan_d;
            drop_q      <= drop_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
        end
    end

    assign sel       = sel_q;
    assign f_out     = f_q;
    assign done      = done_q;
    assign done_chan = done_chan_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_demux16_dispatch.sv
// Directed-vector bench for demux16_dispatch, plus a second instance paired with a behavioural demux.
module tb_demux16_dispatch;

    logic        clk;
    logic        reset;
    logic        in_valid, in_valid2;
    logic        in_ready, in_ready2;
    logic        in_bit;
    logic        in_mode;
    logic [3:0]  in_dest;
    logic [15:0] chan_en;
    logic [15:0] chan_busy;
    logic [3:0]  sel, sel2;
    logic        f_out, f_out2;
    logic        done, done2;
    logic [3:0]  done_chan, done_chan2;
    logic        drop_err, drop_err2;
    logic [15:0] y;

    int errors = 0;
    int checks = 0;

    demux16_dispatch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_bit(in_bit), .in_mode(in_mode), .in_dest(in_dest),
        .chan_en(chan_en), .chan_busy(chan_busy), .sel(sel), .f_out(f_out),
        .done(done), .done_chan(done_chan), .drop_err(drop_err)
    );

    demux16_dispatch #(.SETUP_CYC(2), .PULSE_CYC(3)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_bit(in_bit), .in_mode(in_mode), .in_dest(in_dest),
        .chan_en(chan_en), .chan_busy(chan_busy), .sel(sel2), .f_out(f_out2),
        .done(done2), .done_chan(done_chan2), .drop_err(drop_err2)
    );

    // Behavioural model of the demux tree fed by dut2.
    assign y = f_out2 ? (16'h0001 << sel2) : 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One full transaction on the default instance: accept c0, SETUP c1, PULSE c2-c3, GAP c4, ready c5.
    task automatic run_txn(input logic mode, input logic [3:0] dest, input logic b, input logic [3:0] exp_ch);
        in_mode  = mode;
        in_dest  = dest;
        in_bit   = b;
        in_valid = 1'b1;
        #1;
        check("ready_c0", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("sel_c1", sel, exp_ch);
        check("f_c1", f_out, 0);
        check("ready_c1", in_ready, 0);
        tick();
        check("f_c2", f_out, b);
        check("sel_c2", sel, exp_ch);
        tick();
        check("f_c3", f_out, b);
        check("sel_c3", sel, exp_ch);
        tick();
        check("f_c4", f_out, 0);
        check("done_c4", done, 1);
        check("done_chan_c4", done_chan, exp_ch);
        check("ready_c4", in_ready, 0);
        tick();
        check("done_c5", done, 0);
        check("ready_c5", in_ready, 1);
    endtask

    // Transaction on the SETUP=2/PULSE=3 instance, checking demux outputs every cycle.
    task automatic run_gate(input logic [3:0] dest);
        logic [15:0] oh;
        oh        = 16'h0001 << dest;
        in_mode   = 1'b1;
        in_dest   = dest;
        in_bit    = 1'b1;
        in_valid2 = 1'b1;
        #1;
        check("g_ready", in_ready2, 1);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) in_valid2 = 1'b0;
            check($sformatf("g_y_c%0d", c), y, (c >= 3 && c <= 5) ? oh : 16'h0000);
            check($sformatf("g_sel_c%0d", c), sel2, dest);
            check($sformatf("g_done_c%0d", c), done2, (c == 6) ? 1 : 0);
        end
        check("g_done_chan", done_chan2, dest);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        in_bit    = 1'b0;
        in_mode   = 1'b0;
        in_dest   = 4'd0;
        chan_en   = 16'hFFFF;
        chan_busy = 16'h0000;
        tick();
        tick();
        check("rst_sel", sel, 0);
        check("rst_f", f_out, 0);
        check("rst_done", done, 0);
        check("rst_done_chan", done_chan, 0);
        check("rst_drop", drop_err, 0);
        check("rst_ready", in_ready, 0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", in_ready, 1);

        // Round-robin from reset pointer 15
        for (int k = 0; k < 4; k++) run_txn(1'b0, 4'd0, 1'b1, 4'(k));

        // Wrap with only channels 0 and 15 enabled
        chan_en = 16'h8001;
        do_reset();
        run_txn(1'b0, 4'd0, 1'b1, 4'd0);
        run_txn(1'b0, 4'd0, 1'b1, 4'd15);
        run_txn(1'b0, 4'd0, 1'b1, 4'd0);
        chan_busy = 16'h0001;
        run_txn(1'b0, 4'd0, 1'b1, 4'd15);
        run_txn(1'b0, 4'd0, 1'b1, 4'd15);
        chan_busy = 16'h0000;

        // Directed delivery, then directed drop to a disabled channel
        chan_en = 16'hFFFF;
        run_txn(1'b1, 4'd9, 1'b1, 4'd9);
        chan_en  = 16'hFFDF;
        in_mode  = 1'b1;
        in_dest  = 4'd5;
        in_bit   = 1'b1;
        in_valid = 1'b1;
        #1;
        check("drop_ready_c0", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("drop_err_c1", drop_err, 1);
        check("drop_sel_c1", sel, 9);
        check("drop_f_c1", f_out, 0);
        check("drop_ready_c1", in_ready, 1);
        tick();
        check("drop_err_c2", drop_err, 0);
        check("drop_done_c2", done, 0);
        check("drop_sel_c2", sel, 9);
        // Directed traffic leaves rr_ptr at 15, so the next pick is 0
        run_txn(1'b0, 4'd0, 1'b1, 4'd0);

        // Directed backpressure on channel 3
        chan_busy = 16'h0008;
        in_mode   = 1'b1;
        in_dest   = 4'd3;
        in_valid  = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_ready_%0d", i), in_ready, 0);
            tick();
        end
        check("bp_sel_hold", sel, 0);
        chan_busy = 16'h0000;
        run_txn(1'b1, 4'd3, 1'b1, 4'd3);

        // Round-robin with everything busy
        chan_busy = 16'hFFFF;
        in_mode   = 1'b0;
        in_valid  = 1'b1;
        #1;
        check("allbusy_ready_a", in_ready, 0);
        tick();
        check("allbusy_ready_b", in_ready, 0);
        check("allbusy_sel", sel, 3);
        in_valid  = 1'b0;
        chan_busy = 16'h0000;

        // in_bit=0 still sequences and completes; rr_ptr is 0, next enabled is 1
        run_txn(1'b0, 4'd0, 1'b0, 4'd1);

        // Reset during PULSE aborts the transaction
        in_mode  = 1'b0;
        in_bit   = 1'b1;
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        check("abort_sel_c1", sel, 2);
        tick();
        check("abort_f_c2", f_out, 1);
        reset = 1'b1;
        #1;
        check("abort_ready_in_reset", in_ready, 0);
        tick();
        check("abort_f_c3", f_out, 0);
        check("abort_done_c3", done, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_no_done_%0d", i), done, 0);
        end
        check("abort_idle_ready", in_ready, 1);
        run_txn(1'b0, 4'd0, 1'b1, 4'd0);

        // Gate-level pairing with SETUP_CYC=2, PULSE_CYC=3
        run_gate(4'd6);
        run_gate(4'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
